// File: rtl/user_rio_pkg.sv
// Shared definitions for the NWRITE user-side stream: checker state encoding,
// error bit positions and the tail-beat byte-enable mask.
package user_rio_pkg;

   // Checker states: expecting a header, checking payload, discarding to tlast
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Error vector layout {LEN, KEEP, DATA, HDR}
   localparam int ERR_W    = 4;
   localparam int ERR_HDR  = 0;
   localparam int ERR_DATA = 1;
   localparam int ERR_KEEP = 2;
   localparam int ERR_LEN  = 3;

   typedef logic [ERR_W-1:0] err_t;

   // Left-justified byte enables for the final beat of a payload whose
   // length modulo 8 is rem; a full final beat (rem == 0) enables all bytes.
   function automatic logic [7:0] keep_mask(input logic [2:0] rem);
      logic [7:0] m;
      case (rem)
         3'd1:    m = 8'h80;
         3'd2:    m = 8'hc0;
         3'd3:    m = 8'he0;
         3'd4:    m = 8'hf0;
         3'd5:    m = 8'hf8;
         3'd6:    m = 8'hfc;
         3'd7:    m = 8'hfe;
         default: m = 8'hff;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/user_rx_checker.sv
// User-side sink and checker for the NWRITE target path. Consumes the
// AXI-stream delivered to user logic, checks header, payload, byte enables
// and length against the generator format, and keeps packet/error statistics.
module user_rx_checker
   import user_rio_pkg::*;
#(
   parameter int MAX_SIZE = 4096,
   parameter int CNT_W    = 16
) (
   input  logic             log_clk,
   input  logic             log_rst_n,
   input  logic             user_tvalid_in,
   input  logic [63:0]      user_tdata_in,
   input  logic [7:0]       user_tkeep_in,
   input  logic             user_tlast_in,
   output logic             user_tready_o,
   input  logic             stall_in,
   input  logic             clr_in,
   output logic             pkt_done_o,
   output logic             pkt_ok_o,
   output logic [3:0]       err_vec_o,
   output logic [CNT_W-1:0] pkt_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam logic [31:0] C_MAX_SIZE = 32'(MAX_SIZE);

   // Handshake and FSM state
   logic             r_tready;
   state_e           r_state;
   logic [63:0]      r_exp_data;   // expected value of the next data beat
   logic [9:0]       r_beat_cnt;   // index k of the next data beat (1-based)
   logic [9:0]       r_nbeats;     // data beats the header announced
   logic [7:0]       r_last_keep;  // expected tkeep on beat nbeats
   err_t             r_pkt_err;    // errors collected so far in this packet

   // Registered status outputs
   logic             r_pkt_done;
   logic             r_pkt_ok;
   err_t             r_err_vec;
   logic [CNT_W-1:0] r_pkt_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   // Beat evaluation
   logic             w_accept;
   logic             w_pkt_end;
   logic [12:0]      w_hdr_size;
   logic [9:0]       w_hdr_nbeats;
   logic             w_hdr_bad;
   logic             w_last_beat;
   logic [7:0]       w_exp_keep;
   logic [63:0]      w_byte_mask;
   err_t             w_beat_err;
   err_t             w_end_err;

   assign w_accept     = user_tvalid_in & r_tready;
   assign w_pkt_end    = w_accept & user_tlast_in;

   // Header decode: size = hdr[11:0]+1 spans 1..4096, so it needs 13 bits and
   // the beat count takes size[12:3] to cover the 4096-byte case.
   assign w_hdr_size   = {1'b0, user_tdata_in[11:0]} + 13'd1;
   assign w_hdr_nbeats = w_hdr_size[12:3] + {9'd0, |w_hdr_size[2:0]};
   assign w_hdr_bad    = (|user_tdata_in[63:12])
                       | (32'(w_hdr_size) > C_MAX_SIZE)
                       | user_tlast_in;

   assign w_last_beat  = (r_beat_cnt == r_nbeats);
   assign w_exp_keep   = w_last_beat ? r_last_keep : 8'hff;

   // Classify the incoming beat and form the error set the packet would close with
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path can infer a latch.
      w_byte_mask = '0;
      w_beat_err  = '0;
      w_end_err   = r_pkt_err;

      // tkeep bit i enables byte lane tdata[8*i +: 8]; bit 7 is the first byte
      for (int i = 0; i < 8; i++) begin
         w_byte_mask[8*i +: 8] = {8{w_exp_keep[i]}};
      end

      w_beat_err[ERR_DATA] = |((user_tdata_in ^ r_exp_data) & w_byte_mask);
      w_beat_err[ERR_KEEP] = (user_tkeep_in != w_exp_keep);
      w_beat_err[ERR_LEN]  = (user_tlast_in != w_last_beat);

      case (r_state)
         ST_IDLE: begin
            w_end_err          = '0;
            w_end_err[ERR_HDR] = w_hdr_bad;
         end
         ST_DATA:  w_end_err = r_pkt_err | w_beat_err;
         default:  w_end_err = r_pkt_err;
      endcase
   end

   // Sink ready follows the throttle request one cycle late, regardless of state
   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) begin
         r_tready <= 1'b0;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments only.
         r_tready <= ~stall_in;
      end
   end

   // Packet FSM: header capture, per-beat payload check, drain to tlast
   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) begin
         r_state     <= ST_IDLE;
         r_exp_data  <= '0;
         r_beat_cnt  <= '0;
         r_nbeats    <= '0;
         r_last_keep <= '0;
         r_pkt_err   <= '0;
      end else if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               r_exp_data  <= user_tdata_in + 64'd1;
               r_beat_cnt  <= 10'd1;
               r_nbeats    <= w_hdr_nbeats;
               r_last_keep <= keep_mask(w_hdr_size[2:0]);
               r_pkt_err   <= w_end_err;
               if (user_tlast_in) begin
                  r_state <= ST_IDLE;
               end else if (w_hdr_bad) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               r_exp_data <= r_exp_data + 64'd1;
               r_beat_cnt <= r_beat_cnt + 10'd1;
               r_pkt_err  <= w_end_err;
               if (user_tlast_in) begin
                  r_state <= ST_IDLE;
               end else if (w_last_beat) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (user_tlast_in) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Packet-end pulse and statistics; a clear wins over a same-cycle update
   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) begin
         r_pkt_done <= 1'b0;
         r_pkt_ok   <= 1'b0;
         r_err_vec  <= '0;
         r_pkt_cnt  <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_pkt_done <= w_pkt_end;
         r_pkt_ok   <= w_pkt_end & ~(|w_end_err);
         if (clr_in) begin
            r_err_vec <= '0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
         end else if (w_pkt_end) begin
            r_err_vec <= r_err_vec | w_end_err;
            r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            if (|w_end_err) begin
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign user_tready_o = r_tready;
   assign pkt_done_o    = r_pkt_done;
   assign pkt_ok_o      = r_pkt_ok;
   assign err_vec_o     = r_err_vec;
   assign pkt_cnt_o     = r_pkt_cnt;
   assign err_cnt_o     = r_err_cnt;

endmodule
